load_access_unit: RTL and testbench
===================================

Name: load_access_unit

Overview:
- Sequential memory-read stage between the load-instruction decoder and the register file write port.
- Once a load is decoded, accepts the effective address (ALU result), funct3 and destination register.
- Runs a req/ack read handshake on the data memory port, then byte-aligns and sign/zero-extends the returned word.
- Produces a single-cycle register-file write, or a fault pulse on an illegal, misaligned or timed-out access.

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req may stay high without mem_ack before a timeout fault (>=2)
CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES-1

Ports:
CLK  input  1  processor clock, rising-edge
RST_N  input  1  asynchronous active-low reset
start  input  1  load request; sampled only in IDLE
funct3  input  3  load width/sign code (INSN[14:12])
addr  input  32  effective byte address from ALU
rd_addr  input  5  destination register index
busy  output  1  high whenever state != IDLE
mem_req  output  1  memory read request, held until ack
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_ack  input  1  memory read data valid
mem_rdata  input  32  memory read word, little-endian lanes
rd_we  output  1  register-file write strobe, one cycle
rd_waddr  output  5  register index for write
rd_wdata  output  32  extended load result
fault  output  1  one-cycle error pulse
fault_code  output  2  00 none, 01 illegal funct3, 10 misaligned, 11 timeout

Behaviour:
- Reset (RST_N low, any time, asynchronous): state=IDLE. All outputs 0: busy, mem_req, mem_addr, rd_we, rd_waddr, rd_wdata, fault, fault_code. Timeout counter 0. Any in-flight access is abandoned with no write and no fault.
- All outputs are registered (driven from flops/state only).
- States: IDLE, REQ, WB, ERR.
- IDLE, start=1 at rising edge: latch funct3, addr[1:0], rd_addr; mem_addr <= {addr[31:2],2'b00}. Next state:
  - ERR with code 01 if funct3 is not one of {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - ERR with code 10 if LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - REQ otherwise.
  - Illegal funct3 takes priority over misalignment.
- IDLE, start=0: stay.
- start is ignored in every other state; no queuing.
- REQ: mem_req=1, counter increments each cycle. mem_addr is stable while mem_req is high.
  - mem_ack=1 at an edge: capture extended data into rd_wdata, go to WB.
  - Otherwise, if counter==TIMEOUT_CYCLES-1: go to ERR with code 11.
  - mem_ack at the timeout edge wins: the access completes.
  - mem_ack outside REQ is ignored.
- WB (1 cycle): rd_we=1 and rd_waddr=latched rd, unless rd==0, in which case rd_we=0 (x0 is never written). mem_req=0, counter cleared. Next state IDLE.
- ERR (1 cycle): fault=1 with fault_code. mem_req=0, rd_we=0. Next state IDLE. fault_code returns to 00 in IDLE.
- Latency: start sampled at edge 0 -> mem_req high from edge 0. ack sampled at edge n -> rd_we high for the cycle after edge n. Earliest next start is accepted at edge n+2.
- Extraction, lane select by latched addr[1:0]:
  - Byte = mem_rdata[8*a+7 : 8*a].
  - Half = mem_rdata[16*a[1]+15 : 16*a[1]].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
- rd_wdata holds its last value outside WB.

Test Plan:
- LW addr=0x0000_0104, rd=5, mem_rdata=0xDEAD_BEEF, ack after 3 cycles of req -> mem_addr=0x104, rd_we one cycle, rd_waddr=5, rd_wdata=0xDEADBEEF, total 5 cycles start-to-IDLE.
- LB and LBU at addr offsets 0..3, rdata=0x80FF_7F01 -> LB: 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; LBU: 0x01, 0x7F, 0xFF, 0x80 zero-extended.
- LH addr=0x102 with rdata=0x8001_1234 -> 0xFFFF8001. LHU same -> 0x00008001. LH addr=0x103 -> no mem_req, fault=1 code 10.
- funct3=011 with addr=0x101 -> fault code 01 (not 10), no mem_req. Also rd=0 LW with ack -> handshake completes, rd_we stays 0.
- Timeout: TIMEOUT_CYCLES=16, no ack -> mem_req high exactly 16 cycles, then fault code 11, rd_we never asserts. Repeat with ack on the 16th cycle -> normal WB, no fault.
- Reset mid-REQ and assert start while busy: RST_N low -> all outputs 0 immediately, no write or fault after release. start while busy -> ignored, first access completes unchanged.

Source files
------------

// File: rtl/load_access_unit.sv
// Load access unit: takes a decoded load (address, funct3, rd), runs a
// req/ack read on the data memory port, lane-aligns and extends the returned
// word, then issues a single-cycle register-file write or a fault pulse.
module load_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [4:0]  rd_addr,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rd_we,
  output logic [4:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_MISALGN = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      maddr_q, maddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Select the addressed byte/halfword lane and extend it per the load type.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (f3)
      3'b000:  extend_load = {{24{b[7]}}, b};
      3'b001:  extend_load = {{16{h[15]}}, h};
      3'b100:  extend_load = {24'd0, b};
      3'b101:  extend_load = {16'd0, h};
      default: extend_load = word;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3);
    f3_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Halfwords need an even address, words a 4-byte-aligned address.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                 ((f3 == 3'b010) && (a != 2'b00));
  endfunction

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      rd_q    <= 5'd0;
      maddr_q <= 32'd0;
      wdata_q <= 32'd0;
      code_q  <= CODE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, wait for ack or timeout in REQ, then one WB/ERR cycle.
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rd_d    = rd_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        code_d = CODE_NONE;
        cnt_d  = '0;
        if (start) begin
          f3_d    = funct3;
          off_d   = addr[1:0];
          rd_d    = rd_addr;
          maddr_d = {addr[31:2], 2'b00};
          if (!f3_legal(funct3)) begin
            code_d  = CODE_ILLEGAL;
            state_d = S_ERR;
          end else if (misaligned(funct3, addr[1:0])) begin
            code_d  = CODE_MISALGN;
            state_d = S_ERR;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An ack on the final allowed cycle still completes the access.
        if (mem_ack) begin
          wdata_d = extend_load(f3_q, off_q, mem_rdata);
          cnt_d   = '0;
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          code_d  = CODE_TIMEOUT;
          cnt_d   = '0;
          state_d = S_ERR;
        end
      end
      S_WB: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        code_d  = CODE_NONE;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state.
  assign busy       = (state_q != S_IDLE);
  assign mem_req    = (state_q == S_REQ);
  assign mem_addr   = maddr_q;
  assign rd_we      = (state_q == S_WB) && (rd_q != 5'd0);
  assign rd_waddr   = rd_q;
  assign rd_wdata   = wdata_q;
  assign fault      = (state_q == S_ERR);
  assign fault_code = code_q;

endmodule

// File: tb/tb_load_access_unit.sv
// Directed bench for load_access_unit.
module tb_load_access_unit;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rd_we;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        fault;
  logic [1:0]  fault_code;

  int n_checks = 0;
  int n_fail   = 0;

  load_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .funct3(funct3), .addr(addr),
    .rd_addr(rd_addr), .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rd_we(rd_we), .rd_waddr(rd_waddr),
    .rd_wdata(rd_wdata), .fault(fault), .fault_code(fault_code)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a load for exactly one sampling edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
    start   = 1'b1;
    funct3  = f3;
    addr    = a;
    rd_addr = rd;
    tick();
    start   = 1'b0;
  endtask

  // Acknowledge on the k-th cycle of mem_req (k >= 1); ends in the WB cycle.
  task automatic ack_on(input int k, input logic [31:0] data);
    repeat (k - 1) tick();
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_req"},   32'(mem_req), 32'd0);
    check({tag, "_maddr"}, mem_addr, 32'd0);
    check({tag, "_we"},    32'(rd_we), 32'd0);
    check({tag, "_waddr"}, 32'(rd_waddr), 32'd0);
    check({tag, "_wdata"}, rd_wdata, 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_code"},  32'(fault_code), 32'd0);
  endtask

  logic [31:0] lb_exp  [4];
  logic [31:0] lbu_exp [4];
  int          req_cnt;
  logic        saw_we;
  logic        saw_fault;

  initial begin
    lb_exp[0]  = 32'h0000_0001; lb_exp[1]  = 32'h0000_007F;
    lb_exp[2]  = 32'hFFFF_FFFF; lb_exp[3]  = 32'hFFFF_FF80;
    lbu_exp[0] = 32'h0000_0001; lbu_exp[1] = 32'h0000_007F;
    lbu_exp[2] = 32'h0000_00FF; lbu_exp[3] = 32'h0000_0080;

    RST_N = 1'b0; start = 1'b0; funct3 = 3'd0; addr = 32'd0; rd_addr = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    #12;
    check_all_zero("reset");
    RST_N = 1'b1;
    tick();

    // LW, ack on the 3rd req cycle, 5 cycles start to IDLE.
    issue(3'b010, 32'h0000_0104, 5'd5);
    check("lw_busy", 32'(busy), 32'd1);
    check("lw_req", 32'(mem_req), 32'd1);
    check("lw_maddr", mem_addr, 32'h0000_0104);
    ack_on(3, 32'hDEAD_BEEF);
    check("lw_we", 32'(rd_we), 32'd1);
    check("lw_req_off", 32'(mem_req), 32'd0);
    check("lw_waddr", 32'(rd_waddr), 32'd5);
    check("lw_wdata", rd_wdata, 32'hDEAD_BEEF);
    tick();
    check("lw_idle", 32'(busy), 32'd0);
    check("lw_we_off", 32'(rd_we), 32'd0);
    check("lw_wdata_hold", rd_wdata, 32'hDEAD_BEEF);

    // LB / LBU at each byte offset.
    for (int i = 0; i < 4; i++) begin
      issue(3'b000, 32'h0000_0200 + 32'(i), 5'd3);
      check("lb_maddr", mem_addr, 32'h0000_0200);
      ack_on(1, 32'h80FF_7F01);
      check($sformatf("lb_off%0d", i), rd_wdata, lb_exp[i]);
      tick();
      issue(3'b100, 32'h0000_0200 + 32'(i), 5'd4);
      ack_on(2, 32'h80FF_7F01);
      check($sformatf("lbu_off%0d", i), rd_wdata, lbu_exp[i]);
      tick();
    end

    // Halfword loads from the upper lane.
    issue(3'b001, 32'h0000_0102, 5'd6);
    ack_on(1, 32'h8001_1234);
    check("lh_wdata", rd_wdata, 32'hFFFF_8001);
    tick();
    issue(3'b101, 32'h0000_0102, 5'd6);
    ack_on(1, 32'h8001_1234);
    check("lhu_wdata", rd_wdata, 32'h0000_8001);
    tick();

    // Misaligned halfword.
    issue(3'b001, 32'h0000_0103, 5'd6);
    check("mis_req", 32'(mem_req), 32'd0);
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_code", 32'(fault_code), 32'd2);
    check("mis_we", 32'(rd_we), 32'd0);
    tick();
    check("mis_fault_off", 32'(fault), 32'd0);
    check("mis_code_off", 32'(fault_code), 32'd0);

    // Illegal funct3 outranks misalignment.
    issue(3'b011, 32'h0000_0101, 5'd6);
    check("ill_req", 32'(mem_req), 32'd0);
    check("ill_fault", 32'(fault), 32'd1);
    check("ill_code", 32'(fault_code), 32'd1);
    tick();

    // Write to x0 is suppressed.
    issue(3'b010, 32'h0000_0108, 5'd0);
    check("x0_req", 32'(mem_req), 32'd1);
    ack_on(2, 32'h1234_5678);
    check("x0_busy", 32'(busy), 32'd1);
    check("x0_we", 32'(rd_we), 32'd0);
    tick();
    check("x0_idle", 32'(busy), 32'd0);

    // Timeout with no ack.
    issue(3'b010, 32'h0000_0300, 5'd8);
    req_cnt = 0;
    saw_we  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      req_cnt++;
      if (rd_we) saw_we = 1'b1;
      tick();
    end
    check("to_req_cycles", 32'(req_cnt), 32'd16);
    check("to_fault", 32'(fault), 32'd1);
    check("to_code", 32'(fault_code), 32'd3);
    check("to_we", 32'(rd_we | saw_we), 32'd0);
    tick();
    check("to_idle", 32'(busy), 32'd0);

    // Ack on the final allowed cycle wins.
    issue(3'b010, 32'h0000_0304, 5'd9);
    ack_on(16, 32'hCAFE_F00D);
    check("to16_fault", 32'(fault), 32'd0);
    check("to16_we", 32'(rd_we), 32'd1);
    check("to16_wdata", rd_wdata, 32'hCAFE_F00D);
    tick();

    // Asynchronous reset in the middle of REQ.
    issue(3'b010, 32'h0000_0400, 5'd10);
    tick();
    #1;
    RST_N = 1'b0;
    #1;
    check_all_zero("rst_mid");
    RST_N = 1'b1;
    saw_we    = 1'b0;
    saw_fault = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1;
      tick();
      if (rd_we) saw_we = 1'b1;
      if (fault) saw_fault = 1'b1;
    end
    mem_ack = 1'b0;
    check("rst_no_we", 32'(saw_we), 32'd0);
    check("rst_no_fault", 32'(saw_fault), 32'd0);
    check("rst_idle", 32'(busy), 32'd0);

    // start while busy is ignored.
    issue(3'b010, 32'h0000_0400, 5'd7);
    start = 1'b1; funct3 = 3'b000; addr = 32'h0000_0501; rd_addr = 5'd9;
    tick();
    check("busy_maddr", mem_addr, 32'h0000_0400);
    ack_on(1, 32'h1122_3344);
    check("busy_we", 32'(rd_we), 32'd1);
    check("busy_waddr", 32'(rd_waddr), 32'd7);
    check("busy_wdata", rd_wdata, 32'h1122_3344);
    start = 1'b0;
    tick();
    check("busy_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
